// File: rtl/rdma_fifo_pkg.sv
// Shared definitions for the RDMA FIFO read-side stream adapter.
// Holds the output buffer depth and the circular-buffer pointer type.
package rdma_fifo_pkg;

  // Entries in the output buffer; sized so that one read may be in flight
  // while two words wait, giving one word per cycle without a
  // combinational ready-to-read-enable path.
  localparam int FRS_BUF_DEPTH = 3;

  // Pointer into the output buffer (values 0..2).
  typedef logic [1:0] frs_ptr_t;

  // Advance a buffer pointer, wrapping from the last entry back to 0.
  function automatic frs_ptr_t frs_ptr_inc(input frs_ptr_t p);
    frs_ptr_t n;
    if (p == frs_ptr_t'(FRS_BUF_DEPTH - 1)) begin
      n = 2'd0;
    end else begin
      n = p + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/frs_skid_buf.sv
// Three-entry circular output buffer for fifo_rd_stream.
// Words captured from the FIFO are written at the tail; the stream side
// consumes from the head. Occupancy is tracked explicitly so the read
// issue logic in the top can see how much room remains.
module frs_skid_buf
  import rdma_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_occ,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_mem [FRS_BUF_DEPTH];
  frs_ptr_t              r_head;
  frs_ptr_t              r_tail;
  logic [1:0]            r_occ;
  logic                  w_pop;
  logic                  w_push;

  // Qualify push/pop so an empty buffer is never popped and a full buffer
  // is never written, even if the issue logic were to misbehave.
  always_comb begin
    w_pop  = i_pop & (r_occ != 2'd0);
    w_push = i_push & ((r_occ != 2'(FRS_BUF_DEPTH)) | w_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FRS_BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= frs_ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= frs_ptr_inc(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ   = r_occ;
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_head];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: converts a synchronous FIFO read port (lagging
// empty/almost-empty flags, one-cycle read latency) into a valid/ready
// stream without underrunning the FIFO or dropping words.
// Optional build macro FIFO_RD_STREAM_STATS_EN adds an accepted-word
// counter (i_stat_clr / o_word_cnt ports and CNT_WIDTH parameter).
module fifo_rd_stream
  import rdma_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  parameter int CNT_WIDTH  = 32
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_fifo_rd_en,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_aempty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
`ifdef FIFO_RD_STREAM_STATS_EN
  input  logic                  i_stat_clr,
  output logic [CNT_WIDTH-1:0]  o_word_cnt,
`endif
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data
);

  logic       r_run;
  logic       r_inflt;
  logic [1:0] w_occ;
  logic [2:0] w_fill;
  logic       w_rd_en;
  logic       w_valid;
  logic       w_pop;

  // Read issue. Room is counted including the word already in flight.
  // Because the empty flag lags a read by one cycle, a second consecutive
  // read is only safe while the FIFO is not almost empty.
  always_comb begin
    w_fill  = {1'b0, w_occ} + {2'b00, r_inflt};
    w_rd_en = r_run
            & ~i_fifo_empty
            & (w_fill < 3'(FRS_BUF_DEPTH))
            & (~r_inflt | ~i_fifo_aempty);
  end

  // Run enable (one idle cycle after reset release) and in-flight tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run   <= 1'b0;
      r_inflt <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_inflt <= w_rd_en;
    end
  end

  assign w_pop = w_valid & i_m_ready;

  frs_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_inflt),
    .i_push_data (i_fifo_data),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_valid     (w_valid),
    .o_data      (o_m_data)
  );

  assign o_fifo_rd_en = w_rd_en;
  assign o_m_valid    = w_valid;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] r_word_cnt;

  // Accepted-word counter; a clear takes priority over an increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word_cnt <= '0;
    end else if (i_stat_clr) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: behavioural FIFO with lagging flags,
// scoreboard of written words, monitor checking the stream side.
module tb_fifo_rd_stream;

  localparam int DW     = 32;
  localparam int TH_AE  = 8;

  logic          clk;
  logic          rst_n;
  logic          rd_en;
  logic          f_empty;
  logic          f_aempty;
  logic [DW-1:0] f_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          wr_en;
  logic [DW-1:0] wr_data;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic          stat_clr;
  logic [31:0]   word_cnt;
  logic [31:0]   cnt_m;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] fq[$];     // FIFO contents
  logic [DW-1:0] exp_q[$];  // expected stream order
  int issued   = 0;
  int accepted = 0;
  int cur_run  = 0;
  int max_run  = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_fifo_rd_en  (rd_en),
    .i_fifo_empty  (f_empty),
    .i_fifo_aempty (f_aempty),
    .i_fifo_data   (f_dout),
`ifdef FIFO_RD_STREAM_STATS_EN
    .i_stat_clr    (stat_clr),
    .o_word_cnt    (word_cnt),
`endif
    .o_m_valid     (m_valid),
    .i_m_ready     (m_ready),
    .o_m_data      (m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: flags are registered from the occupancy before the
  // current edge's update, so they lag a read by one cycle.
  int pre_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      f_empty  <= 1'b1;
      f_aempty <= 1'b1;
      f_dout   <= '0;
    end else begin
      pre_cnt = fq.size();
      if (rd_en && fq.size() > 0) f_dout <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      f_empty  <= (pre_cnt == 0);
      f_aempty <= (pre_cnt <= TH_AE);
    end
  end

  // Stream monitor / scoreboard.
  logic [DW-1:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      cur_run    = 0;
`ifdef FIFO_RD_STREAM_STATS_EN
      cnt_m      = 0;
`endif
    end else begin
      if (rd_en) begin
        issued++;
        checks++;
        if (fq.size() == 0) begin
          failures++;
          $display("FAIL underrun: read issued with fifo count=%0d required>0", fq.size());
        end
      end
      if (prev_stall) begin
        checks++;
        if (!m_valid || m_data !== prev_data) begin
          failures++;
          $display("FAIL hold: valid=%0b data=%08h required valid=1 data=%08h", m_valid, m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        accepted++;
        cur_run++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL data: unexpected word %08h, required none", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            failures++;
            $display("FAIL data: got %08h required %08h", m_data, e);
          end
        end
      end else begin
        cur_run = 0;
      end
      if (cur_run > max_run) max_run = cur_run;
      checks++;
      if (issued - accepted > 3) begin
        failures++;
        $display("FAIL occupancy: buffered+inflight=%0d required<=3", issued - accepted);
      end
`ifdef FIFO_RD_STREAM_STATS_EN
      checks++;
      if (word_cnt !== cnt_m) begin
        failures++;
        $display("FAIL word_cnt: got %0d required %0d", word_cnt, cnt_m);
      end
      if (stat_clr) cnt_m = 0;
      else if (m_valid && m_ready) cnt_m = cnt_m + 1;
`endif
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [DW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    exp_q.push_back(w);
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic preload(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fq.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (accepted < target && n < budget) begin
      cyc();
      n++;
    end
    chk(name, 64'(accepted >= target), 64'd1);
  endtask

  int e_cyc, r_cyc, v_cyc, nrd, nv, base, nr;

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
`ifdef FIFO_RD_STREAM_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) cyc();
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("rst_cnt", 64'(word_cnt), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_cycle_rd_en", 64'(rd_en), 64'd0);
    cyc();
    repeat (3) cyc();

    // Single word: one read, one valid cycle, two-cycle latency.
    m_ready = 1'b1;
    wr_word(32'hA5A5_0001);
    e_cyc = -1; r_cyc = -1; v_cyc = -1; nrd = 0; nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!f_empty && e_cyc < 0) e_cyc = c;
      if (rd_en) begin nrd++; r_cyc = c; end
      if (m_valid) begin nv++; v_cyc = c; end
    end
    cyc();
    chk("single_reads", 64'(nrd), 64'd1);
    chk("single_valid_cycles", 64'(nv), 64'd1);
    chk("single_rd_latency", 64'(r_cyc - e_cyc), 64'd0);
    chk("single_valid_latency", 64'(v_cyc - e_cyc), 64'd2);

    // 16 preloaded words with ready high.
    repeat (3) cyc();
    max_run = 0;
    base = accepted;
    preload(16);
    wait_acc("burst16_done", base + 16, 200);
    repeat (4) cyc();
    chk("burst16_fifo_empty", 64'(fq.size()), 64'd0);
    chk("burst16_no_extra_read", 64'(issued - accepted), 64'd0);
    chk("burst16_b2b_run", 64'(max_run >= 8), 64'd1);

    // Back-pressure: 10 words, ready low for 20 cycles.
    m_ready = 1'b0;
    base = issued;
    preload(10);
    repeat (20) cyc();
    chk("stall_reads", 64'(issued - base), 64'd3);
    chk("stall_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    wait_acc("stall_drain", base + 10, 200);
    repeat (4) cyc();
    chk("stall_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two buffered words and one read in flight.
    m_ready = 1'b0;
    preload(10);
    nr = 0;
    for (int c = 0; c < 50 && nr < 3; c++) begin
      @(negedge clk);
      if (rd_en) nr++;
    end
    chk("rst_mid_third_read", 64'(nr), 64'd3);
    cyc();
    chk("rst_mid_pre_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(m_valid), 64'd0);
    chk("rst_mid_data", 64'(m_data), 64'd0);
    exp_q.delete();
    fq.delete();
    issued   = 0;
    accepted = 0;
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_first_rd_en", 64'(rd_en), 64'd0);
    cyc();

    // Random writes and random ready, 1000 words.
    base = accepted;
    begin
      int written;
      int n;
      written = 0;
      n = 0;
      while (written < 1000 && n < 20000) begin
        m_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          wr_en   = 1'b1;
          wr_data = $urandom;
          exp_q.push_back(wr_data);
          written++;
        end else begin
          wr_en = 1'b0;
        end
        cyc();
        n++;
      end
      wr_en = 1'b0;
    end
    m_ready = 1'b1;
    wait_acc("random_drain", base + 1000, 5000);
    repeat (4) cyc();
    chk("random_scoreboard_empty", 64'(exp_q.size()), 64'd0);

`ifdef FIFO_RD_STREAM_STATS_EN
    // 37 words, clear on the last accept, then 5 more.
    base = accepted;
    preload(37);
    wait_acc("stats_36", base + 36, 300);
    begin
      int n;
      n = 0;
      while (!m_valid && n < 20) begin
        cyc();
        n++;
      end
    end
    chk("stats_37th_valid", 64'(m_valid), 64'd1);
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    chk("stats_clr", 64'(word_cnt), 64'd0);
    base = accepted;
    preload(5);
    wait_acc("stats_5_done", base + 5, 100);
    repeat (2) cyc();
    chk("stats_5", 64'(word_cnt), 64'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter placed directly downstream of the RDMA datapath's synchronous FIFO. It converts the FIFO's raw read port (registered empty/almost-empty flags that lag occupancy, 1-cycle read-data latency) into a valid/ready stream. It never underruns the FIFO and never drops a word under back-pressure. A 3-entry output buffer sustains one word per cycle with no combinational path from `i_m_ready` to the FIFO read enable.

## Interface
- `DATA_WIDTH`, 32, stream and FIFO word width.
- `CNT_WIDTH`, 32, width of the transfer counter (only with `FIFO_RD_STREAM_STATS_EN`).
- `i_clk`  in  1  single clock; the FIFO runs on the same clock.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `o_fifo_rd_en`  out  1  read request to the FIFO (`i_rd_en`).
- `i_fifo_empty`  in  1  FIFO `o_empty`.
- `i_fifo_aempty`  in  1  FIFO `o_aempty`.
- `i_fifo_data`  in  DATA_WIDTH  FIFO `o_data_out`; valid the cycle after a read.
- `o_m_valid`  out  1  stream word available.
- `i_m_ready`  in  1  downstream accepts.
- `o_m_data`  out  DATA_WIDTH  stream word (head of buffer).
- `i_stat_clr`  in  1  synchronous counter clear (stats build only).
- `o_word_cnt`  out  CNT_WIDTH  accepted-word count (stats build only).

## Operation
- Registered state:
  - `r_occ` (0..3): buffer occupancy.
  - `r_inflt`: a read was issued last cycle.
  - `r_run`: goes 1 the first clock after reset release.
  - 3-entry circular buffer with 2-bit head and tail pointers, wrapping 2→0.
- Read issue:
  - `o_fifo_rd_en = r_run & !i_fifo_empty & (r_occ + r_inflt < 3) & (!r_inflt | !i_fifo_aempty)`.
  - The FIFO's empty flag lags one cycle behind a read. When the FIFO is almost empty, this rule allows at most one read every two cycles.
  - Back-to-back reads are allowed only while `i_fifo_aempty` is low.
  - Integration requirement: FIFO `TH_AEMPTY` ≥ 3.
- Capture: when `r_inflt` = 1, write `i_fifo_data` at the tail and advance the tail.
- Pop: when `o_m_valid & i_m_ready`, advance the head.
- Occupancy update:
  - push and pop in the same cycle: `r_occ` unchanged;
  - push only: +1;
  - pop only: −1.
- `o_m_valid = (r_occ != 0)`.
- `o_m_data` = entry at head.
- Data stays stable while `o_m_valid & !i_m_ready` (AXI-style hold).
- The read issue rule guarantees `r_occ` never exceeds 3. An overflow attempt is a design error; the bench asserts on it.

## Timing
- Reset values:
  - `o_m_valid` = 0;
  - `o_fifo_rd_en` = 0 (gated by `r_run`, including the first cycle after release);
  - `o_m_data` = 0;
  - `o_word_cnt` = 0;
  - all pointers, `r_occ` and `r_inflt` = 0.
- Latency: FIFO empty low in cycle N → `o_fifo_rd_en` in N → data captured at end of N+1 → `o_m_valid` high in N+2.
- Throughput: 1 word/cycle sustained while `i_fifo_aempty` = 0 and `i_m_ready` = 1.
- Back-pressure: with `i_m_ready` low, reads stop once `r_occ + r_inflt` = 3; there is no loss.
- Reset mid-operation: buffer and in-flight word are discarded. The FIFO must be reset in the same cycle, since its own reset is synchronous active-high, driven from `!i_rst_n`.

## Configuration
- `FIFO_RD_STREAM_STATS_EN` defined:
  - `o_word_cnt` increments on each `o_m_valid & i_m_ready` and wraps at 2^CNT_WIDTH.
  - `i_stat_clr` zeroes it next cycle; clear wins over a simultaneous increment.
- Not defined: `i_stat_clr` and `o_word_cnt` ports and the counter logic are absent.

## Structure
- Shared package `rdma_fifo_pkg`: buffer depth constant `FRS_BUF_DEPTH = 3` and the 2-bit pointer type.
- One sub-module `frs_skid_buf`: the 3-entry buffer with its push/pop/occupancy logic. The top holds the read-issue logic and stats.

## Test plan
- Write 1 word 0xA5A5_0001 into an empty FIFO with `i_m_ready` = 1 → exactly one `o_fifo_rd_en` pulse; `o_m_valid` for one cycle with 0xA5A5_0001; no second read.
- Preload 16 words (TH_AEMPTY = 8) with `i_m_ready` = 1 → 16 words in order. Throughput is 1/cycle while aempty is low, then 1 per 2 cycles; no FIFO underrun (read address = write address at the end).
- Preload 10 words and hold `i_m_ready` = 0 for 20 cycles → `r_occ` = 3 and exactly 3 reads issued. On release, all 10 words come out in order; data held stable during the stall.
- Random `i_m_ready` (50%) with random writes, 1000 words → scoreboard matches; `r_occ` ≤ 3 always.
- Assert `i_rst_n` low while `r_occ` = 2 and a read is in flight → `o_m_valid` = 0 immediately. After release, `o_fifo_rd_en` stays 0 for the first cycle.
- Stats build: transfer 37 words, pulse `i_stat_clr` in the same cycle as an accept → `o_word_cnt` = 0 next cycle; then 5 more words → 5.
